// File: rtl/fifo_pop_stream.sv
// FIFO read stage: pops the FIFO read port into a head/skid buffer and drives a registered valid/ready stream.
// Optional transfer/stall statistics counters are enabled with FIFO_POP_STREAM_STATS_EN.
module fifo_pop_stream #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_read_data,
  output logic             fifo_pop,
  input  logic             flush,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [width-1:0] down_data,
  output logic [31:0]      xfer_count,
  output logic [31:0]      stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } count_t;

  count_t           count_q, count_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] skid_q, skid_d;
  logic             xfer;
  logic             has_room;

  assign down_valid = (count_q != EMPTY);
  assign down_data  = head_q;
  assign xfer       = down_valid & down_ready;

  // Room is judged from registered state only, so the pop never waits on down_ready.
  assign has_room = (count_q == EMPTY) | (count_q == ONE);
  assign fifo_pop = !fifo_empty & has_room & !flush & rst_n;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      count_d = EMPTY;
    end else begin
      case (count_q)
        EMPTY: begin
          if (fifo_pop) begin
            head_d  = fifo_read_data;
            count_d = ONE;
          end
        end
        ONE: begin
          if (fifo_pop && !xfer) begin
            skid_d  = fifo_read_data;
            count_d = TWO;
          end else if (fifo_pop && xfer) begin
            head_d = fifo_read_data;
          end else if (xfer) begin
            count_d = EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            head_d  = skid_q;
            count_d = ONE;
          end
        end
        default: count_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef FIFO_POP_STREAM_STATS_EN
  logic [31:0] xfer_count_q, xfer_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Counters wrap naturally and ignore flush.
  always_comb begin
    xfer_count_d  = xfer ? xfer_count_q + 32'd1 : xfer_count_q;
    stall_count_d = (down_valid && !down_ready) ? stall_count_q + 32'd1 : stall_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q  <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      xfer_count_q  <= xfer_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign xfer_count  = xfer_count_q;
  assign stall_count = stall_count_q;
`else
  assign xfer_count  = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Scoreboard bench for fifo_pop_stream with a behavioural FIFO feeding it.
// Counter expectations follow FIFO_POP_STREAM_STATS_EN.
module tb_fifo_pop_stream;

  localparam int W = 8;
`ifdef FIFO_POP_STREAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_read_data;
  logic         fifo_pop;
  logic         flush = 1'b0;
  logic         down_valid;
  logic         down_ready = 1'b0;
  logic [W-1:0] down_data;
  logic [31:0]  xfer_count;
  logic [31:0]  stall_count;

  logic [W-1:0] fmem [0:255];
  logic [7:0]   wr_ptr = 8'd0;
  logic [7:0]   rd_ptr;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] want;
  int           errors = 0;
  int           checks = 0;
  int unsigned  exp_xfer = 0, exp_stall = 0, cur_xfer = 0, cur_stall = 0;
  int           pop_viol = 0;
  logic         xf;
  logic [W-1:0] dd;

  fifo_pop_stream #(.width(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_read_data(fifo_read_data),
    .fifo_pop      (fifo_pop),
    .flush         (flush),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_data     (down_data),
    .xfer_count    (xfer_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO sharing the DUT reset; reset discards its contents.
  assign fifo_empty     = (rd_ptr == wr_ptr);
  assign fifo_read_data = fmem[rd_ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ptr <= wr_ptr;
    else if (fifo_pop && !fifo_empty) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic push_word(input logic [W-1:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(v);
  endtask

  // One cycle: drive inputs after the falling edge, then sample what the next rising edge will see.
  task automatic tick(input logic rdy, input logic fl);
    @(negedge clk);
    down_ready = rdy;
    flush = fl;
    #1;
    xf = down_valid & down_ready;
    dd = down_data;
    cur_xfer = exp_xfer;
    cur_stall = exp_stall;
    if (STATS && xf) exp_xfer++;
    if (STATS && down_valid && !down_ready) exp_stall++;
    if (fifo_pop && fifo_empty) pop_viol++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (down_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL rst_pop: got %b want 0", fifo_pop); end
    checks++; if (down_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_data: got %h want 00", down_data); end
    checks++; if (xfer_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_xfer: got %0d want 0", xfer_count); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("[TB] FAIL rst_stall: got %0d want 0", stall_count); end
    push_word(8'h5A);
    #1;
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL rst_pop_forced: got %b want 0", fifo_pop); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (dd !== 8'h11) begin errors++; $display("[TB] FAIL two_head: got %h want 11", dd); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL two_nopop: got %b want 0", fifo_pop); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (down_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pop: got %b want 0", fifo_pop); end
    checks++; if (down_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data: got %h want 00", down_data); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("[TB] FAIL midrst_stall: got %0d want 0", stall_count); end
    exp_q.delete();
    exp_xfer = 0;
    exp_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_word(8'hA5);
    #1;
    checks++; if (fifo_pop !== 1'b1) begin errors++; $display("[TB] FAIL a5_pop: got %b want 1", fifo_pop); end
    tick(1'b0, 1'b0);
    checks++; if (down_valid !== 1'b1 || dd !== exp_q[0]) begin errors++; $display("[TB] FAIL a5_latency: got valid=%b data=%h want valid=1 data=%h", down_valid, dd, exp_q[0]); end
    tick(1'b1, 1'b0);
    checks++;
    if (!xf) begin errors++; $display("[TB] FAIL a5_xfer: got xfer=0 want 1"); end
    else begin want = exp_q.pop_front(); if (dd !== want) begin errors++; $display("[TB] FAIL a5_data: got %h want %h", dd, want); end end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_streaming;
    int unsigned base;
    base = exp_xfer;
    for (int i = 1; i <= 16; i++) push_word(W'(i));
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (!xf) begin errors++; $display("[TB] FAIL stream_bubble: cycle %0d got xfer=0 want 1", i); end
      else begin want = exp_q.pop_front(); if (dd !== want) begin errors++; $display("[TB] FAIL stream_data: got %h want %h", dd, want); end end
      checks++; if (xfer_count !== cur_xfer) begin errors++; $display("[TB] FAIL stream_cnt: got %0d want %0d", xfer_count, cur_xfer); end
    end
    tick(1'b0, 1'b0);
    checks++; if (xfer_count !== (STATS ? base + 32'd16 : 32'd0)) begin errors++; $display("[TB] FAIL stream_total: got %0d want %0d", xfer_count, STATS ? base + 16 : 0); end
    checks++; if (stall_count !== cur_stall) begin errors++; $display("[TB] FAIL stream_stall: got %0d want %0d", stall_count, cur_stall); end
  endtask

  task automatic test_backpressure;
    logic [7:0] rd_start;
    rd_start = rd_ptr;
    push_word(8'hB0);
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    repeat (6) tick(1'b0, 1'b0);
    checks++; if (8'(rd_ptr - rd_start) !== 8'd2) begin errors++; $display("[TB] FAIL bp_pops: got %0d want 2", 8'(rd_ptr - rd_start)); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL bp_nopop: got %b want 0", fifo_pop); end
    checks++; if (down_valid !== 1'b1 || dd !== exp_q[0]) begin errors++; $display("[TB] FAIL bp_hold: got valid=%b data=%h want valid=1 data=%h", down_valid, dd, exp_q[0]); end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      tick(1'b1, 1'b0);
      if (xf) begin
        checks++; want = exp_q.pop_front();
        if (dd !== want) begin errors++; $display("[TB] FAIL bp_order: got %h want %h", dd, want); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_drain: %0d words left want 0", exp_q.size()); end
    tick(1'b0, 1'b0);
    checks++; if (stall_count !== cur_stall) begin errors++; $display("[TB] FAIL bp_stall: got %0d want %0d", stall_count, cur_stall); end
  endtask

  task automatic test_alternating;
    int unsigned base;
    base = exp_stall;
    for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      tick(i % 2 == 0, 1'b0);
      if (xf) begin
        checks++; want = exp_q.pop_front();
        if (dd !== want) begin errors++; $display("[TB] FAIL alt_order: got %h want %h", dd, want); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL alt_drain: %0d words left want 0", exp_q.size()); end
    tick(1'b0, 1'b0);
    checks++; if (stall_count !== (STATS ? base + 32'd7 : 32'd0)) begin errors++; $display("[TB] FAIL alt_stall: got %0d want %0d", stall_count, STATS ? base + 7 : 0); end
    checks++; if (pop_viol != 0) begin errors++; $display("[TB] FAIL pop_when_empty: got %0d events want 0", pop_viol); end
  endtask

  task automatic test_flush;
    push_word(8'hD0);
    push_word(8'hD1);
    push_word(8'hD2);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (fifo_pop !== 1'b0 || dd !== exp_q[0]) begin errors++; $display("[TB] FAIL fl_two: got pop=%b data=%h want pop=0 data=%h", fifo_pop, dd, exp_q[0]); end
    tick(1'b1, 1'b1);
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL fl_pop: got %b want 0", fifo_pop); end
    checks++;
    if (!xf) begin errors++; $display("[TB] FAIL fl_xfer: got xfer=0 want 1"); end
    else begin want = exp_q.pop_front(); if (dd !== want) begin errors++; $display("[TB] FAIL fl_data: got %h want %h", dd, want); end end
    want = exp_q.pop_front();
    tick(1'b1, 1'b1);
    checks++; if (down_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_empty: got %b want 0", down_valid); end
    checks++; if (fifo_pop !== 1'b0) begin errors++; $display("[TB] FAIL fl_pop_held: got %b want 0", fifo_pop); end
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      tick(1'b1, 1'b0);
      if (xf) begin
        checks++; want = exp_q.pop_front();
        if (dd !== want) begin errors++; $display("[TB] FAIL fl_after: got %h want %h", dd, want); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL fl_drain: %0d words left want 0", exp_q.size()); end
    tick(1'b0, 1'b0);
    checks++; if (xfer_count !== cur_xfer) begin errors++; $display("[TB] FAIL fl_xcnt: got %0d want %0d", xfer_count, cur_xfer); end
    checks++; if (stall_count !== cur_stall) begin errors++; $display("[TB] FAIL fl_scnt: got %0d want %0d", stall_count, cur_stall); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_alternating();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
